// File: rtl/vga_pmod_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vga_pmod_monitor
// Brief    : Receive-side monitor for a TinyVGA PMOD bus. Locks to HSync and
//            VSync, recovers pixel coordinates and 6-bit colour, and flags
//            sync timing violations against the configured video mode.
// Options  : define VGA_MON_FRAME_CRC_EN to build a per-frame CRC-16/CCITT
//            over the recovered pixels (frame_crc is tied to 0 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
module vga_pmod_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_NEG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic [7:0]  pmod_in,
  input  logic        clr_err,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [5:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic [15:0] frame_count,
  output logic [15:0] frame_crc
);

  localparam logic        SYNC_INV  = (SYNC_NEG != 0);
  localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
  localparam logic [10:0] H_TOTAL_W = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] H_START_W = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_W   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC);
  localparam logic [10:0] V_TOTAL_W = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] V_START_W = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END_W   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  H_OFS     = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  V_OFS     = 10'(V_SYNC + V_BP);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_ALIGN  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        hs;
  logic        vs;
  logic        hs_prev;
  logic        vs_prev;
  logic        hs_rise;
  logic        hs_fall;
  logic        vs_rise;
  logic        vs_fall;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic [10:0] h_inc;
  logic [10:0] v_inc;
  logic        checking;
  logic        skip_line;
  logic        align_bad;
  logic        fail_h;
  logic        fail_v;
  logic        fail;
  logic        active;
  logic        emit;
  logic [5:0]  rgb;

  // Decoded syncs are active-high regardless of bus polarity.
  assign hs      = pmod_in[7] ^ SYNC_INV;
  assign vs      = pmod_in[3] ^ SYNC_INV;
  assign hs_rise = hs & ~hs_prev;
  assign hs_fall = ~hs & hs_prev;
  assign vs_rise = vs & ~vs_prev;
  assign vs_fall = ~vs & vs_prev;
  assign rgb     = {pmod_in[0], pmod_in[4], pmod_in[1], pmod_in[5], pmod_in[2], pmod_in[6]};

  // h_cnt / v_cnt hold the position of the previous sample; *_nxt is the
  // position of the sample on the bus right now.
  assign h_inc = {1'b0, h_cnt} + 11'd1;
  assign v_inc = {1'b0, v_cnt} + 11'd1;
  assign h_nxt = hs_rise ? 10'd0 : ((h_cnt == 10'h3FF) ? h_cnt : h_cnt + 10'd1);
  assign v_nxt = !hs_rise ? v_cnt : (vs_rise ? 10'd0 : v_cnt + 10'd1);

  assign checking = sample_en && (state != S_HUNT);

  assign fail_h = checking &&
                  ((hs_fall && (h_inc != H_SYNC_W)) ||
                   (hs_rise && !skip_line && (h_inc != H_TOTAL_W)));

  assign fail_v = checking &&
                  (((vs_rise || vs_fall) && !hs_rise) ||
                   (hs_rise && vs_rise && (v_inc != V_TOTAL_W)) ||
                   (hs_rise && vs_fall && (v_inc != V_SYNC_W)));

  assign fail = fail_h || fail_v;

  assign active = ({1'b0, h_nxt} >= H_START_W) && ({1'b0, h_nxt} < H_END_W) &&
                  ({1'b0, v_nxt} >= V_START_W) && ({1'b0, v_nxt} < V_END_W);

  assign emit   = sample_en && active && (state == S_LOCKED);
  assign locked = (state == S_LOCKED);

  // Sync history and raster counters advance only on sample strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      h_cnt   <= 10'd0;
      v_cnt   <= 10'd0;
    end else if (sample_en) begin
      hs_prev <= hs;
      vs_prev <= vs;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a frame must pass every check in ALIGN before locking.
  always_comb begin
    state_nxt = state;
    if (sample_en) begin
      case (state)
        S_HUNT:   if (vs_rise) state_nxt = S_ALIGN;
        S_ALIGN:  if (vs_rise && !fail && !align_bad) state_nxt = S_LOCKED;
        S_LOCKED: if (fail) state_nxt = S_HUNT;
        default:  state_nxt = S_HUNT;
      endcase
    end
  end

  // Frame-failure memory for ALIGN and the skip of the first line's period check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_bad <= 1'b0;
      skip_line <= 1'b1;
    end else if (sample_en) begin
      if (state != S_ALIGN || vs_rise) begin
        align_bad <= 1'b0;
      end else if (fail) begin
        align_bad <= 1'b1;
      end
      if (state == S_HUNT) begin
        skip_line <= 1'b1;
      end else if (hs_rise) begin
        skip_line <= 1'b0;
      end
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_h <= 1'b0;
      err_v <= 1'b0;
    end else begin
      err_h <= (err_h & ~clr_err) | fail_h;
      err_v <= (err_v & ~clr_err) | fail_v;
    end
  end

  // Count frame boundaries seen while locked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count <= 16'd0;
    end else if (sample_en && vs_rise && (state == S_LOCKED)) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  // Pixel output stage; coordinates and colour hold between pixels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 6'd0;
    end else begin
      pix_valid   <= emit;
      frame_start <= emit && (h_nxt == H_OFS) && (v_nxt == V_OFS);
      if (emit) begin
        pix_x   <= h_nxt - H_OFS;
        pix_y   <= v_nxt - V_OFS;
        pix_rgb <= rgb;
      end
    end
  end

`ifdef VGA_MON_FRAME_CRC_EN
  logic [15:0] crc_acc;
  logic [15:0] crc_cur;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction

  // Fold in the pixel leaving the output stage this cycle, if any.
  assign crc_cur = pix_valid ? crc_byte(crc_acc, {2'b00, pix_rgb}) : crc_acc;

  // Accumulate per frame; publish and restart at each frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_acc   <= 16'hFFFF;
      frame_crc <= 16'd0;
    end else if (sample_en && vs_rise) begin
      crc_acc <= 16'hFFFF;
      if (state == S_LOCKED) begin
        frame_crc <= crc_cur;
      end
    end else begin
      crc_acc <= crc_cur;
    end
  end
`else
  assign frame_crc = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_pmod_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pmod_monitor
// Brief    : Self-checking bench for vga_pmod_monitor using a reduced video
//            mode, a frame generator with random colours and sample spacing,
//            and a coordinate scoreboard built from the generated raster.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pmod_monitor;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 8;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int SN = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  localparam int M_NORM  = 0;
  localparam int M_LONG  = 1;
  localparam int M_VSKEW = 2;
  localparam int M_VW3   = 3;
  localparam int M_BLACK = 4;
  localparam int BAD_LINE = VS + VB + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic [7:0]  pmod_in = 8'h88;
  logic        clr_err = 1'b0;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  pix_rgb;
  logic        frame_start;
  logic        locked;
  logic        err_h;
  logic        err_v;
  logic [15:0] frame_count;
  logic [15:0] frame_crc;

  typedef struct {
    int         x;
    int         y;
    logic [5:0] rgb;
  } pix_t;

  pix_t   exp_q[$];
  pix_t   e;
  int     n_chk = 0;
  int     n_err = 0;
  int     gap = 1;
  bit     rgap = 1'b0;
  bit     gap_chk = 1'b0;
  bit     color_probe = 1'b0;
  int     pix_seen = 0;
  int     pix_expected = 0;
  logic   prev_pv = 1'b0;
  logic [15:0] exp_crc;

  vga_pmod_monitor #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_NEG(SN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .pmod_in    (pmod_in),
    .clr_err    (clr_err),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_start(frame_start),
    .locked     (locked),
    .err_h      (err_h),
    .err_v      (err_v),
    .frame_count(frame_count),
    .frame_crc  (frame_crc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  // Bus bits: [0]R1 [1]G1 [2]B1 [3]VSync [4]R0 [5]G0 [6]B0 [7]HSync; rgb = {R1,R0,G1,G0,B1,B0}.
  function automatic logic [7:0] enc_bus(input bit h, input bit v, input logic [5:0] c);
    return {h ^ 1'(SN), c[0], c[2], c[4], v ^ 1'(SN), c[1], c[3], c[5]};
  endfunction

  // Serial CRC-16/CCITT over a run of zero bytes.
  function automatic logic [15:0] crc_zero_bytes(input int nbytes);
    logic [15:0] c;
    bit          fb;
    c = 16'hFFFF;
    for (int i = 0; i < nbytes * 8; i++) begin
      fb = c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic drive(input logic [7:0] b, input bit clr);
    int n;
    n = rgap ? int'($urandom_range(1, 3)) : gap;
    pmod_in   = b;
    sample_en = 1'b1;
    clr_err   = clr;
    @(posedge clk); #1;
    sample_en = 1'b0;
    clr_err   = 1'b0;
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int mode, input bit expect_px, input int stop_at);
    int         n;
    int         len;
    bit         h;
    bit         v;
    bit         act;
    bit         clr;
    logic [5:0] c;
    logic [7:0] b;
    pix_t       p;
    n = 0;
    for (int l = 0; l < VT; l++) begin
      len = (mode == M_LONG && l == BAD_LINE) ? HT + 1 : HT;
      for (int s = 0; s < len; s++) begin
        h   = (s < HS);
        v   = (mode == M_VW3) ? (l < 3) : (l < VS);
        clr = 1'b0;
        if (mode == M_VSKEW && l == 0 && s < 10) v = 1'b0;
        if (mode == M_VSKEW && l == 0 && s == 10) clr = 1'b1;
        act = (s >= HS + HB) && (s < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA);
        c   = (mode == M_BLACK) ? 6'd0 : 6'($urandom);
        b   = enc_bus(h, v, c);
        if (act && mode != M_BLACK && (s - (HS + HB)) == 5 && (l - (VS + VB)) == 7) begin
          c = 6'b100100;
          b = {b[7], 3'b010, b[3], 3'b001};
        end
        if (act && expect_px && !(mode == M_LONG && l > BAD_LINE)) begin
          p.x = s - (HS + HB);
          p.y = l - (VS + VB);
          p.rgb = c;
          exp_q.push_back(p);
          pix_expected++;
        end
        drive(b, clr);
        n++;
        if (stop_at >= 0 && n > stop_at) return;
      end
    end
  endtask

  task automatic garbage_lines(input int k);
    int len;
    for (int i = 0; i < k; i++) begin
      len = int'($urandom_range(5, 30));
      for (int s = 0; s < len; s++) drive(enc_bus(s < HS, 1'b0, 6'($urandom)), 1'b0);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_pix_valid"}, 32'(pix_valid), 0);
    check_eq({tag, "_pix_x"}, 32'(pix_x), 0);
    check_eq({tag, "_pix_y"}, 32'(pix_y), 0);
    check_eq({tag, "_pix_rgb"}, 32'(pix_rgb), 0);
    check_eq({tag, "_frame_start"}, 32'(frame_start), 0);
    check_eq({tag, "_locked"}, 32'(locked), 0);
    check_eq({tag, "_err_h"}, 32'(err_h), 0);
    check_eq({tag, "_err_v"}, 32'(err_v), 0);
    check_eq({tag, "_frame_count"}, 32'(frame_count), 0);
    check_eq({tag, "_frame_crc"}, 32'(frame_crc), 0);
  endtask

  task automatic do_reset(input bit verify);
    rst = 1'b1;
    sample_en = 1'b0;
    clr_err = 1'b0;
    pmod_in = enc_bus(1'b0, 1'b0, 6'd0);
    exp_q.delete();
    pix_seen = 0;
    pix_expected = 0;
    repeat (2) @(posedge clk);
    #1;
    if (verify) check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  // Scoreboard: every pix_valid must match the next generated active pixel.
  always @(negedge clk) begin
    if (!rst) begin
      if (pix_valid) begin
        pix_seen++;
        if (gap_chk) check_eq("pix_valid_run", 32'(prev_pv), 0);
        if (exp_q.size() == 0) begin
          check_eq("pix_unexpected", 32'(pix_valid), 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("pix_x", 32'(pix_x), e.x);
          check_eq("pix_y", 32'(pix_y), e.y);
          check_eq("pix_rgb", 32'(pix_rgb), 32'(e.rgb));
          check_eq("frame_start", 32'(frame_start), (e.x == 0 && e.y == 0) ? 1 : 0);
          if (color_probe && e.x == 5 && e.y == 7) check_eq("rgb_at_5_7", 32'(pix_rgb), 32'b100100);
        end
      end
      prev_pv = pix_valid;
    end else begin
      prev_pv = 1'b0;
    end
  end

  initial begin
`ifdef VGA_MON_FRAME_CRC_EN
    exp_crc = crc_zero_bytes(HA * VA);
`else
    exp_crc = 16'd0;
`endif

    // Nominal video, one sample per clock, random colours.
    do_reset(1'b1);
    color_probe = 1'b1;
    garbage_lines(3);
    send_frame(M_NORM, 1'b0, -1);
    check_eq("nom_locked_f1", 32'(locked), 0);
    send_frame(M_NORM, 1'b1, -1);
    check_eq("nom_locked_f2", 32'(locked), 1);
    repeat (3) send_frame(M_NORM, 1'b1, -1);
    check_eq("nom_frame_count", 32'(frame_count), 3);
    check_eq("nom_err_h", 32'(err_h), 0);
    check_eq("nom_err_v", 32'(err_v), 0);
    check_eq("nom_pix_total", pix_seen, HA * VA * 4);
    check_eq("nom_queue_left", exp_q.size(), 0);

    // Over-long line while locked, then recovery.
    send_frame(M_LONG, 1'b1, -1);
    check_eq("long_locked", 32'(locked), 0);
    check_eq("long_err_h", 32'(err_h), 1);
    check_eq("long_err_v", 32'(err_v), 0);
    send_frame(M_NORM, 1'b0, -1);
    send_frame(M_NORM, 1'b1, -1);
    check_eq("relock_locked", 32'(locked), 1);
    check_eq("relock_err_h_sticky", 32'(err_h), 1);
    pulse_clr();
    check_eq("clr_err_h", 32'(err_h), 0);
    check_eq("long_pix_total", pix_seen, pix_expected);

    // VSync edge 10 samples after HSync, with clr_err landing on the same sample.
    send_frame(M_VSKEW, 1'b0, -1);
    check_eq("vskew_err_v", 32'(err_v), 1);
    check_eq("vskew_locked", 32'(locked), 0);
    send_frame(M_NORM, 1'b0, -1);
    send_frame(M_NORM, 1'b1, -1);
    check_eq("vskew_relock", 32'(locked), 1);
    pulse_clr();
    check_eq("clr_err_v", 32'(err_v), 0);
    check_eq("vskew_queue_left", exp_q.size(), 0);
    color_probe = 1'b0;

    // VSync three lines wide never locks.
    do_reset(1'b0);
    repeat (3) send_frame(M_VW3, 1'b0, -1);
    check_eq("vw3_err_v", 32'(err_v), 1);
    check_eq("vw3_err_h", 32'(err_h), 0);
    check_eq("vw3_locked", 32'(locked), 0);
    check_eq("vw3_pix_total", pix_seen, 0);

    // One sample every fourth clock.
    do_reset(1'b0);
    gap = 4;
    gap_chk = 1'b1;
    send_frame(M_NORM, 1'b0, -1);
    repeat (4) send_frame(M_NORM, 1'b1, -1);
    check_eq("slow_frame_count", 32'(frame_count), 3);
    check_eq("slow_locked", 32'(locked), 1);
    check_eq("slow_pix_total", pix_seen, HA * VA * 4);
    gap = 1;
    gap_chk = 1'b0;

    // All-black frames with irregular sample spacing: frame CRC.
    do_reset(1'b0);
    rgap = 1'b1;
    send_frame(M_BLACK, 1'b0, -1);
    send_frame(M_BLACK, 1'b1, -1);
    send_frame(M_BLACK, 1'b1, -1);
    check_eq("crc_frame_a", 32'(frame_crc), 32'(exp_crc));
    send_frame(M_BLACK, 1'b1, -1);
    check_eq("crc_frame_b", 32'(frame_crc), 32'(exp_crc));
    check_eq("crc_pix_total", pix_seen, HA * VA * 3);
    rgap = 1'b0;

    // Reset asserted while an active pixel is on the outputs.
    send_frame(M_NORM, 1'b1, (VS + VB + 1) * HT + HS + HB + 3);
    check_eq("midrst_pix_before", 32'(pix_valid), 1);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    do_reset(1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
